// File: rtl/accelerator_hls_deadlock_param_monitor.sv
// Deadlock monitor for HLS dataflow regions: flags a persistent state where every
// process is stopped and at least one is stalled on a qualified AXI-Stream port.
module accelerator_hls_deadlock_param_monitor #(
    parameter int NUM_PROC       = 4,
    parameter int CONFIRM_CYCLES = 4,
    parameter int STICKY         = 1,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic [NUM_PROC-1:0] axis_block_sigs,
    input  logic                sub_block,
    output logic                block,
    output logic [NUM_PROC-1:0] block_snapshot,
    output logic [CNT_W-1:0]    deadlock_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CONFIRM  = 2'd1,
        S_DEADLOCK = 2'd2
    } state_t;

    localparam logic [7:0]       LP_LAST    = 8'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_confirm_cnt;
    logic [7:0]          w_confirm_cnt_next;
    logic                r_block;
    logic [NUM_PROC-1:0] r_snapshot;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_PROC-1:0] w_axis_blk;
    logic [NUM_PROC-1:0] w_stop;
    logic                w_candidate;
    logic                w_entry;

    // Axis stalls only count when the child monitor also reports a block.
    generate
        for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_proc
            assign w_axis_blk[gi] = sub_block & axis_block_sigs[gi];
            assign w_stop[gi]     = inst_idle_sigs[gi] | inst_block_sigs[gi] | w_axis_blk[gi];
        end
    endgenerate

    assign w_candidate = (|w_axis_blk) & (&w_stop) & enable;

    always_comb begin
        w_state_next       = r_state;
        w_confirm_cnt_next = r_confirm_cnt;
        w_entry            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_candidate) begin
                    if (CONFIRM_CYCLES == 1) begin
                        w_state_next       = S_DEADLOCK;
                        w_confirm_cnt_next = 8'd0;
                        w_entry            = 1'b1;
                    end else begin
                        w_state_next       = S_CONFIRM;
                        w_confirm_cnt_next = 8'd1;
                    end
                end
            end
            S_CONFIRM: begin
                if (!w_candidate) begin
                    w_state_next       = S_IDLE;
                    w_confirm_cnt_next = 8'd0;
                end else if (r_confirm_cnt == LP_LAST) begin
                    w_state_next       = S_DEADLOCK;
                    w_confirm_cnt_next = 8'd0;
                    w_entry            = 1'b1;
                end else begin
                    w_confirm_cnt_next = r_confirm_cnt + 8'd1;
                end
            end
            S_DEADLOCK: begin
                if (STICKY != 0) begin
                    if (clear) w_state_next = S_IDLE;
                end else if (!w_candidate || clear) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next       = S_IDLE;
                w_confirm_cnt_next = 8'd0;
            end
        endcase
        // A simultaneous clear cancels the entry but the event is still counted.
        if (clear && w_entry) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_confirm_cnt <= 8'd0;
            r_block       <= 1'b0;
            r_snapshot    <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_confirm_cnt <= w_confirm_cnt_next;
            r_block       <= (r_state == S_DEADLOCK);
            if (clear) begin
                r_snapshot <= '0;
            end else if (w_entry) begin
                r_snapshot <= w_axis_blk;
            end
            if (w_entry && (r_count != LP_CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign block          = r_block;
    assign block_snapshot = r_snapshot;
    assign deadlock_count = r_count;

endmodule

// File: tb/tb_accelerator_hls_deadlock_param_monitor.sv
// Directed bench: sticky (CONFIRM=4), non-sticky (CONFIRM=4) and non-sticky
// CONFIRM=1 / 2-bit-counter instances share one stimulus stream.
module tb_accelerator_hls_deadlock_param_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [3:0] idle_sigs;
    logic [3:0] iblk_sigs;
    logic [3:0] axis_sigs;
    logic       sub_block;

    logic       s_block, n_block, c_block;
    logic [3:0] s_snap, n_snap, c_snap;
    logic [7:0] s_cnt, n_cnt;
    logic [1:0] c_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    accelerator_hls_deadlock_param_monitor #(
        .NUM_PROC(4), .CONFIRM_CYCLES(4), .STICKY(1), .CNT_W(8)
    ) u_s (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .inst_idle_sigs(idle_sigs), .inst_block_sigs(iblk_sigs),
        .axis_block_sigs(axis_sigs), .sub_block(sub_block),
        .block(s_block), .block_snapshot(s_snap), .deadlock_count(s_cnt)
    );

    accelerator_hls_deadlock_param_monitor #(
        .NUM_PROC(4), .CONFIRM_CYCLES(4), .STICKY(0), .CNT_W(8)
    ) u_n (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .inst_idle_sigs(idle_sigs), .inst_block_sigs(iblk_sigs),
        .axis_block_sigs(axis_sigs), .sub_block(sub_block),
        .block(n_block), .block_snapshot(n_snap), .deadlock_count(n_cnt)
    );

    accelerator_hls_deadlock_param_monitor #(
        .NUM_PROC(4), .CONFIRM_CYCLES(1), .STICKY(0), .CNT_W(2)
    ) u_c (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .inst_idle_sigs(idle_sigs), .inst_block_sigs(iblk_sigs),
        .axis_block_sigs(axis_sigs), .sub_block(sub_block),
        .block(c_block), .block_snapshot(c_snap), .deadlock_count(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] idl, input logic [3:0] ib,
                         input logic [3:0] ax, input logic sb);
        enable    = en;
        idle_sigs = idl;
        iblk_sigs = ib;
        axis_sigs = ax;
        sub_block = sb;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_block"}, 32'(s_block), 32'd0);
        chk({tag, "_s_snap"},  32'(s_snap),  32'd0);
        chk({tag, "_s_cnt"},   32'(s_cnt),   32'd0);
        chk({tag, "_n_block"}, 32'(n_block), 32'd0);
        chk({tag, "_n_snap"},  32'(n_snap),  32'd0);
        chk({tag, "_n_cnt"},   32'(n_cnt),   32'd0);
        chk({tag, "_c_block"}, 32'(c_block), 32'd0);
        chk({tag, "_c_snap"},  32'(c_snap),  32'd0);
        chk({tag, "_c_cnt"},   32'(c_cnt),   32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(2);
        chk_all_zero("reset");
        reset = 1'b0;

        // Basic detection: block rises on the 5th edge after the first candidate.
        drive(1'b1, 4'b0111, 4'h0, 4'b1000, 1'b1);
        step(1);
        chk("c1_cnt_edge1", 32'(c_cnt), 32'd1);
        step(1);
        chk("c1_block_edge2", 32'(c_block), 32'd1);
        step(2);
        chk("det_block_edge4", 32'(s_block), 32'd0);
        step(1);
        chk("det_block_edge5", 32'(s_block), 32'd1);
        chk("det_snap", 32'(s_snap), 32'h8);
        chk("det_cnt", 32'(s_cnt), 32'd1);
        chk("det_n_block", 32'(n_block), 32'd1);
        chk("c1_snap", 32'(c_snap), 32'h8);
        step(1);
        chk("det_block_edge6", 32'(s_block), 32'd1);

        // Inputs removed: sticky holds, non-sticky releases.
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(10);
        chk("sticky_hold_block", 32'(s_block), 32'd1);
        chk("sticky_hold_snap", 32'(s_snap), 32'h8);
        chk("nonsticky_release", 32'(n_block), 32'd0);
        chk("nonsticky_snap_hold", 32'(n_snap), 32'h8);
        chk("c1_release", 32'(c_block), 32'd0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_snap_zero", 32'(s_snap), 32'd0);
        chk("clear_block_lag", 32'(s_block), 32'd1);
        chk("clear_n_snap_zero", 32'(n_snap), 32'd0);
        step(1);
        chk("clear_block_zero", 32'(s_block), 32'd0);
        chk("clear_cnt_kept", 32'(s_cnt), 32'd1);

        // Interrupted run restarts the confirm counter.
        drive(1'b1, 4'b0111, 4'h0, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("burst1_block", 32'(s_block), 32'd0);
        end
        sub_block = 1'b0;
        step(1);
        chk("gap_block", 32'(s_block), 32'd0);
        sub_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("burst2_block", 32'(s_block), 32'd0);
        end
        step(1);
        chk("burst2_block_set", 32'(s_block), 32'd1);
        chk("burst2_s_cnt", 32'(s_cnt), 32'd2);
        chk("burst2_n_cnt", 32'(n_cnt), 32'd2);
        chk("burst2_c_cnt", 32'(c_cnt), 32'd3);

        // Non-sticky release on sub_block drop, then retriggers; 2-bit counter saturates.
        sub_block = 1'b0;
        step(1);
        chk("ns_drop_lag", 32'(n_block), 32'd1);
        step(1);
        chk("ns_drop_block", 32'(n_block), 32'd0);
        for (int r = 0; r < 2; r++) begin
            sub_block = 1'b1;
            step(5);
            chk("retrig_block", 32'(n_block), 32'd1);
            chk("retrig_cnt", 32'(n_cnt), 32'(3 + r));
            sub_block = 1'b0;
            step(2);
            chk("retrig_release", 32'(n_block), 32'd0);
        end
        chk("sat_c_cnt", 32'(c_cnt), 32'd3);
        chk("sticky_ignores_cand_block", 32'(s_block), 32'd1);
        chk("sticky_ignores_cand_cnt", 32'(s_cnt), 32'd2);

        // Reset in sticky DEADLOCK, then in CONFIRM with counter at 2.
        drive(1'b1, 4'b0111, 4'h0, 4'b1000, 1'b1);
        reset = 1'b1;
        step(1);
        chk_all_zero("rst_deadlock");
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        chk("rst_confirm_block", 32'(s_block), 32'd0);
        chk("rst_confirm_cnt", 32'(s_cnt), 32'd0);
        reset = 1'b0;
        step(4);
        chk("post_rst_block_edge4", 32'(s_block), 32'd0);
        step(1);
        chk("post_rst_block_edge5", 32'(s_block), 32'd1);
        chk("post_rst_cnt", 32'(s_cnt), 32'd1);

        // No candidate without sub_block, nor with enable low.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drive(1'b1, 4'b1111, 4'h0, 4'b1111, 1'b0);
        step(6);
        chk("nosub_s_block", 32'(s_block), 32'd0);
        chk("nosub_c_block", 32'(c_block), 32'd0);
        chk("nosub_c_cnt", 32'(c_cnt), 32'd0);
        drive(1'b0, 4'b1111, 4'h0, 4'b1111, 1'b1);
        step(6);
        chk("noen_s_block", 32'(s_block), 32'd0);
        chk("noen_c_block", 32'(c_block), 32'd0);
        chk("noen_c_cnt", 32'(c_cnt), 32'd0);

        // Clear coincident with entry: entry suppressed but counted.
        enable = 1'b1;
        clear  = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_entry_cnt", 32'(c_cnt), 32'd1);
        chk("clr_entry_snap", 32'(c_snap), 32'd0);
        step(1);
        chk("clr_entry_block", 32'(c_block), 32'd0);
        chk("clr_entry_reentry_cnt", 32'(c_cnt), 32'd2);
        chk("clr_entry_reentry_snap", 32'(c_snap), 32'hF);
        step(1);
        chk("clr_entry_block_late", 32'(c_block), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accelerator_hls_deadlock_param_monitor.md
ACCELERATOR_HLS_DEADLOCK_PARAM_MONITOR -- requirements
Module: accelerator_hls_deadlock_param_monitor

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4, number of monitored dataflow processes (legal 1..32).
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 4, consecutive candidate cycles required before declaring deadlock (legal 1..255).
REQ-003 SHALL have parameter STICKY, default 1; 1 = block holds until clear, 0 = block follows condition.
REQ-004 SHALL have parameter CNT_W, default 8, width of the deadlock event counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 enable  input  1  monitoring enable; 0 holds FSM in IDLE.
REQ-009 clear  input  1  one-cycle pulse; releases sticky DEADLOCK and clears snapshot.
REQ-010 inst_idle_sigs  input  NUM_PROC  per-process idle.
REQ-011 inst_block_sigs  input  NUM_PROC  per-process internal-channel blocked.
REQ-012 axis_block_sigs  input  NUM_PROC  per-process AXI-Stream port blocked.
REQ-013 sub_block  input  1  block output of child monitor; qualifies axis blocks.
REQ-014 block  output  1  registered deadlock indication.
REQ-015 block_snapshot  output  NUM_PROC  axis-blocked process vector captured at detection.
REQ-016 deadlock_count  output  CNT_W  number of IDLE/CONFIRM->DEADLOCK entries, saturating.

Function
REQ-017 SHALL compute axis_blk[i] = sub_block & axis_block_sigs[i] combinationally.
REQ-018 SHALL compute stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | axis_blk[i].
REQ-019 SHALL define candidate = (|axis_blk) & (&stop) & enable.
REQ-020 SHALL implement FSM states IDLE, CONFIRM, DEADLOCK, registered.
REQ-021 IDLE: candidate -> CONFIRM with confirm counter = 1; if CONFIRM_CYCLES = 1 go directly to DEADLOCK.
REQ-022 CONFIRM: candidate and counter = CONFIRM_CYCLES-1 -> DEADLOCK; candidate otherwise -> counter+1; !candidate -> IDLE, counter = 0.
REQ-023 DEADLOCK, STICKY=1: remain until clear=1, then IDLE; candidate ignored.
REQ-024 DEADLOCK, STICKY=0: !candidate or clear -> IDLE; else remain.
REQ-025 block SHALL be 1 exactly in the cycle after FSM register equals DEADLOCK (i.e. registered from state; asserts CONFIRM_CYCLES+1 cycles after first candidate cycle).
REQ-026 On entry to DEADLOCK, block_snapshot SHALL load axis_blk; it holds otherwise; clear zeroes it.
REQ-027 deadlock_count SHALL increment by 1 on each DEADLOCK entry, saturating at 2^CNT_W-1; clear does not affect it.
REQ-028 enable=0 SHALL force IDLE next cycle from any state except sticky DEADLOCK, which only clear releases.
REQ-029 clear and DEADLOCK entry in same cycle: clear wins; state IDLE, snapshot 0, counter still increments.
REQ-030 Confirm counter width SHALL be 8 bits; never wraps (bounded by CONFIRM_CYCLES).
REQ-031 No combinational path from any input to any output.

Reset
REQ-032 reset=1 SHALL set state IDLE, confirm counter 0, block 0, block_snapshot 0, deadlock_count 0, next edge.
REQ-033 reset mid-CONFIRM or in DEADLOCK SHALL abort to IDLE regardless of clear/enable; reset dominates all inputs.

Verification
REQ-034 NUM_PROC=4, CONFIRM=4: idle=4'b0111, axis=4'b1000, sub_block=1 held 6 cycles -> block=1 from 5th cycle after first candidate, snapshot=4'b1000, count=1.
REQ-035 Same stimulus but candidate drops after 3 cycles, then returns 4 -> block stays 0 during the first burst; counter restarts, block=1 only after the second run completes.
REQ-036 STICKY=1: in DEADLOCK drop all inputs to 0 for 10 cycles -> block stays 1; clear pulse -> block=0 two cycles later, snapshot=0, count unchanged.
REQ-037 STICKY=0: in DEADLOCK deassert sub_block -> block=0 two cycles later; re-trigger 3 times -> count=3; CNT_W=2 with 5 triggers -> count=3 (saturation).
REQ-038 sub_block=0 with all processes idle/blocked and axis=4'b1111 -> no candidate, block stays 0; enable=0 with full candidate -> block stays 0.
REQ-039 Assert reset in CONFIRM (counter=2) and in sticky DEADLOCK -> all outputs 0 next cycle, count=0.
